// File: rtl/sram_pkg.sv
// sram_pkg: shared types and helpers for the masked single-port SRAM model.
//   state_e      - array controller state (init sweep / accepting requests)
//   seg_width    - bits covered by one write-mask segment
//   latency_ok   - legal read-latency range
//   mask_ok      - data width divides evenly into mask segments
package sram_pkg;

  typedef enum logic [0:0] {
    S_INIT  = 1'b0,
    S_READY = 1'b1
  } state_e;

  function automatic int seg_width(input int dw, input int segs);
    return dw / segs;
  endfunction

  function automatic bit latency_ok(input int lat);
    return (lat >= 1) && (lat <= 3);
  endfunction

  function automatic bit mask_ok(input int dw, input int segs);
    return (segs > 0) && ((dw % segs) == 0);
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// sram_rd_pipe: read-response pipeline, LAT stages of valid+data.
//   clock, reset      - rising-edge clock, synchronous active-high reset
//   in_valid/in_data  - read data sampled at the fire edge
//   out_valid         - one-cycle pulse per read, LAT cycles after fire
//   out_data          - response data; held (HOLD=1) or zeroed (HOLD=0) when idle
module sram_rd_pipe #(
  parameter int W    = 32,
  parameter int LAT  = 1,
  parameter int HOLD = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [LAT:1]         vld_pipe;
  logic [LAT:1][W-1:0]  dat_pipe;

  // Data stages load only alongside a valid, so the last stage naturally
  // keeps the most recent response between reads.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= in_valid;
      if (in_valid) dat_pipe[1] <= in_data;
      for (int s = 2; s <= LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
      end
    end
  end

  assign out_valid = vld_pipe[LAT];
  assign out_data  = ((HOLD != 0) || vld_pipe[LAT]) ? dat_pipe[LAT] : '0;

endmodule

// File: rtl/sram_sp_masked.sv
// sram_sp_masked: single-port synchronous SRAM with per-segment write mask,
// configurable read latency and a self-initialising sweep after reset.
//   clock, reset   - rising-edge clock, synchronous active-high reset
//   req_valid/req_ready, req_write, req_addr, req_wdata, req_wmask
//                  - one request per cycle, fires on valid && ready
//   resp_valid/resp_rdata - read response READ_LATENCY cycles after fire
//   init_done      - sweep finished, array accepting requests
module sram_sp_masked
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 128,
  parameter int ADDR_WIDTH    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int MASK_SEGS     = 4,
  parameter int READ_LATENCY  = 1,
  parameter int HOLD_READ     = 1,
  parameter int INIT_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [MASK_SEGS-1:0]  req_wmask,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  init_done
);

  localparam int SEG = seg_width(DATA_WIDTH, MASK_SEGS);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST      = ADDR_WIDTH'(DEPTH - 1);

  if (!latency_ok(READ_LATENCY)) begin : g_bad_latency
    $error("sram_sp_masked: READ_LATENCY must be 1..3");
  end
  if (!mask_ok(DATA_WIDTH, MASK_SEGS)) begin : g_bad_mask
    $error("sram_sp_masked: DATA_WIDTH must divide evenly by MASK_SEGS");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  state_e                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  fire, wr_fire, rd_fire, addr_oor;
  logic [DATA_WIDTH-1:0] rd_data;

  // Init sweep: one word per cycle, hand over to READY after the last word.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt   <= '0;
      state <= (INIT_ON_RESET != 0) ? S_INIT : S_READY;
    end else if (state == S_INIT) begin
      cnt <= cnt + 1'b1;
      if (cnt == LAST) state <= S_READY;
    end
  end

  assign req_ready = (state == S_READY);
  assign init_done = req_ready;

  // Only reachable for non-power-of-two depths.
  assign addr_oor = ({1'b0, req_addr} >= DEPTH_EXT);
  assign fire     = req_valid && req_ready;
  assign wr_fire  = fire && req_write;
  assign rd_fire  = fire && !req_write;

  // Storage has no reset of its own; contents are only rewritten by the sweep.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == S_INIT) begin
        mem[cnt] <= INIT_VALUE;
      end else if (wr_fire && !addr_oor) begin
        for (int i = 0; i < MASK_SEGS; i++)
          if (req_wmask[i]) mem[req_addr][i*SEG +: SEG] <= req_wdata[i*SEG +: SEG];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (!addr_oor) rd_data = mem[req_addr];
  end

  always_ff @(posedge clock) begin
    if (!reset && fire)
      assert (!addr_oor)
        else $warning("sram_sp_masked: out-of-range access to address %0d", req_addr);
  end

  sram_rd_pipe #(
    .W    (DATA_WIDTH),
    .LAT  (READ_LATENCY),
    .HOLD (HOLD_READ)
  ) u_rd_pipe (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (rd_fire),
    .in_data   (rd_data),
    .out_valid (resp_valid),
    .out_data  (resp_rdata)
  );

endmodule

// File: tb/tb_sram_sp_masked.sv
// tb_sram_sp_masked: three configurations driven by one shared request bus.
//   u0: DEPTH=128, READ_LATENCY=1, HOLD_READ=1
//   u1: DEPTH=128, READ_LATENCY=3, HOLD_READ=0
//   u2: DEPTH=100, READ_LATENCY=2, HOLD_READ=1 (non-power-of-two depth)
// Reads push expected data and due cycle per instance; a negedge monitor pops.
module tb_sram_sp_masked;

  localparam logic [31:0] IV = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [6:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wmask = '0;

  logic        ready0, ready1, ready2, rv0, rv1, rv2, done0, done1, done2;
  logic [31:0] rd0, rd1, rd2;

  sram_sp_masked #(.DEPTH(128), .READ_LATENCY(1), .HOLD_READ(1), .INIT_VALUE(IV)) u0 (
    .clock(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready0),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wmask(req_wmask), .resp_valid(rv0), .resp_rdata(rd0), .init_done(done0));

  sram_sp_masked #(.DEPTH(128), .READ_LATENCY(3), .HOLD_READ(0), .INIT_VALUE(IV)) u1 (
    .clock(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready1),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wmask(req_wmask), .resp_valid(rv1), .resp_rdata(rd1), .init_done(done1));

  sram_sp_masked #(.DEPTH(100), .READ_LATENCY(2), .HOLD_READ(1), .INIT_VALUE(IV)) u2 (
    .clock(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready2),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wmask(req_wmask), .resp_valid(rv2), .resp_rdata(rd2), .init_done(done2));

  typedef struct {
    int          dut;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mem_m [128];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  logic [2:0]       mon_rv;
  logic [2:0][31:0] mon_rd;
  assign mon_rv = {rv2, rv1, rv0};
  assign mon_rd = {rd2, rd1, rd0};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 2;
  endfunction

  function automatic int depth_of(input int k);
    return (k == 2) ? 100 : 128;
  endfunction

  // Scoreboard monitor: each instance's responses arrive in order.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int idx;
      idx = -1;
      for (int j = 0; j < sbq.size(); j++)
        if (idx < 0 && sbq[j].dut == k) idx = j;
      if (mon_rv[k]) begin
        n_cmp++;
        if (idx < 0) begin
          n_bad++;
          $display("FAIL unexpected_resp u%0d: resp_valid=1 data=%h at cycle %0d, required no response",
                   k, mon_rd[k], cyc);
        end else begin
          if (mon_rd[k] !== sbq[idx].data || cyc != sbq[idx].due) begin
            n_bad++;
            $display("FAIL read_resp u%0d: got %h at cycle %0d, required %h at cycle %0d",
                     k, mon_rd[k], cyc, sbq[idx].data, sbq[idx].due);
          end
          sbq.delete(idx);
        end
      end else if (idx >= 0 && sbq[idx].due <= cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL missing_resp u%0d: no resp_valid at cycle %0d, required %h", k, cyc, sbq[idx].data);
        sbq.delete(idx);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  // Reset for one edge; reads not yet visible before that edge are dropped.
  task automatic do_reset;
    idle();
    reset = 1'b1;
    for (int j = sbq.size() - 1; j >= 0; j--)
      if (sbq[j].due >= cyc + 1) sbq.delete(j);
    tick();
    reset = 1'b0;
    for (int a = 0; a < 128; a++) mem_m[a] = IV;
  endtask

  task automatic do_write(input int addr, input logic [31:0] data, input logic [3:0] mask);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 7'(addr);
    req_wdata = data; req_wmask = mask;
    for (int i = 0; i < 4; i++)
      if (mask[i]) mem_m[addr][i*8 +: 8] = data[i*8 +: 8];
    tick();
  endtask

  task automatic do_read(input int addr);
    exp_t e;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 7'(addr);
    req_wdata = '0; req_wmask = '0;
    for (int k = 0; k < 3; k++) begin
      e.dut  = k;
      e.data = (addr >= depth_of(k)) ? 32'h0 : mem_m[addr];
      e.due  = cyc + lat_of(k);
      sbq.push_back(e);
    end
    tick();
  endtask

  task automatic drain;
    idle();
    for (int i = 0; i < 20 && sbq.size() > 0; i++) tick();
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  // Counts edges from the end of reset until each init_done rises. A write
  // request is held for the first spam_cycles edges; it must be ignored.
  task automatic wait_init(input string tag, input int spam_cycles);
    int first [3];
    int rdy_first [3];
    first = '{-1, -1, -1};
    rdy_first = '{-1, -1, -1};
    if (spam_cycles > 0) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = 7'd3;
      req_wdata = 32'h0; req_wmask = 4'hF;
    end
    for (int n = 1; n <= 300; n++) begin
      if (n > spam_cycles) idle();
      tick();
      if (done0 && first[0] < 0) first[0] = n;
      if (done1 && first[1] < 0) first[1] = n;
      if (done2 && first[2] < 0) first[2] = n;
      if (ready0 && rdy_first[0] < 0) rdy_first[0] = n;
      if (ready1 && rdy_first[1] < 0) rdy_first[1] = n;
      if (ready2 && rdy_first[2] < 0) rdy_first[2] = n;
      if (first[0] > 0 && first[1] > 0 && first[2] > 0 &&
          rdy_first[0] > 0 && rdy_first[1] > 0 && rdy_first[2] > 0) break;
    end
    idle();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (first[k] !== depth_of(k) || rdy_first[k] !== depth_of(k)) begin
        n_bad++;
        $display("FAIL %s_sweep u%0d: init_done at %0d, req_ready at %0d, required both at %0d",
                 tag, k, first[k], rdy_first[k], depth_of(k));
      end
    end
  endtask

  task automatic test_reset;
    logic [34:0] got [3];
    do_reset();
    got[0] = {ready0, done0, rv0, rd0};
    got[1] = {ready1, done1, rv1, rd1};
    got[2] = {ready2, done2, rv2, rd2};
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (got[k] !== 35'h0) begin
        n_bad++;
        $display("FAIL reset_state u%0d: {ready,done,valid,rdata}=%h, required 0", k, got[k]);
      end
    end
    wait_init("reset", 0);
  endtask

  task automatic test_init_reads;
    do_read(0);
    do_read(77);
    do_read(127);
    drain();
  endtask

  task automatic test_mask;
    do_write(5, 32'h11223344, 4'hF);
    do_write(5, 32'hFFFFFFFF, 4'b0101);
    do_read(5);
    drain();
    n_cmp++;
    if (mem_m[5] !== 32'h11FF33FF) begin
      n_bad++;
      $display("FAIL mask_model: model %h, required 11ff33ff", mem_m[5]);
    end
    do_write(6, 32'hCAFEF00D, 4'hF);
    do_write(6, 32'h00000000, 4'h0);
    do_read(6);
    drain();
  endtask

  task automatic test_back_to_back;
    do_write(1, 32'h01010101, 4'hF);
    do_write(2, 32'h02020202, 4'hF);
    do_write(3, 32'h03030303, 4'hF);
    idle(); tick();
    do_read(1);
    do_read(2);
    do_read(3);
    drain();
  endtask

  task automatic test_rw_order;
    do_read(10);
    do_write(10, 32'h0BADCAFE, 4'hF);
    do_read(10);
    do_write(11, 32'h5A5A1234, 4'b1100);
    do_read(11);
    drain();
  endtask

  task automatic test_hold;
    do_write(20, 32'hDEADBEEF, 4'hF);
    do_read(20);
    drain();
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if ({rv0, rv1, rv2} !== 3'b000 || rd0 !== 32'hDEADBEEF ||
          rd2 !== 32'hDEADBEEF || rd1 !== 32'h0) begin
        n_bad++;
        $display("FAIL hold_idle: valid=%b rd0=%h rd1=%h rd2=%h, required 000 deadbeef 00000000 deadbeef",
                 {rv0, rv1, rv2}, rd0, rd1, rd2);
      end
    end
  endtask

  task automatic test_oor;
    do_write(110, 32'h12345678, 4'hF);
    do_write(99, 32'hCAFEF00D, 4'hF);
    do_read(110);
    do_read(99);
    drain();
  endtask

  task automatic test_mid_init_reset;
    do_reset();
    for (int i = 0; i < 40; i++) tick();
    n_cmp++;
    if ({ready0, ready1, ready2, done0, done1, done2} !== 6'b0) begin
      n_bad++;
      $display("FAIL mid_init_ready: ready=%b done=%b, required 000 000",
               {ready0, ready1, ready2}, {done0, done1, done2});
    end
    do_reset();
    wait_init("restart", 0);
    do_read(77);
    do_read(99);
    drain();
  endtask

  task automatic test_mid_ready_reset;
    do_write(30, 32'h76543210, 4'hF);
    do_read(30);
    do_reset();
    wait_init("ready_reset", 60);
    do_read(3);
    do_read(30);
    drain();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 128; a++) mem_m[a] = IV;
    test_reset();
    test_init_reads();
    test_mask();
    test_back_to_back();
    test_rw_order();
    test_hold();
    test_oor();
    test_mid_init_reset();
    test_mid_ready_reset();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_sp_masked.md
Name: sram_sp_masked

Overview:
- Parametrised single-port synchronous SRAM behavioural model for cache and predictor arrays; generalises the fixed 128x32 single-port macro model.
- Adds per-segment write mask, configurable read latency, hold-read output and a self-initialising reset sweep.
- Sits under the SRAM template wrappers; array logic instantiates it in place of hard macros in simulation and FPGA builds.

Parameters:
- DATA_WIDTH, 32, bits per word.
- DEPTH, 128, number of words; need not be a power of two.
- ADDR_WIDTH, clog2(DEPTH), address bits.
- MASK_SEGS, 4, write-mask segments; DATA_WIDTH % MASK_SEGS == 0 is required (elaboration error otherwise).
- READ_LATENCY, 1, cycles from accepted read to response; legal range 1..3.
- HOLD_READ, 1, 1: rdata holds the last response; 0: rdata is zero when resp_valid=0.
- INIT_ON_RESET, 1, 1: sweep INIT_VALUE into every word after reset.
- INIT_VALUE, 0, DATA_WIDTH-bit word written during the sweep.

Ports:
- clock  in  1  Clock; all logic on the rising edge.
- reset  in  1  Synchronous, active-high reset.
- req_valid  in  1  Request present.
- req_ready  out  1  Array can accept a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  Word address.
- req_wdata  in  DATA_WIDTH  Write data.
- req_wmask  in  MASK_SEGS  Per-segment write enable; bit i covers bits [i*SEG+SEG-1 : i*SEG], where SEG = DATA_WIDTH/MASK_SEGS.
- resp_valid  out  1  Read data valid, one-cycle pulse per read.
- resp_rdata  out  DATA_WIDTH  Read data.
- init_done  out  1  Reset sweep complete.

Behaviour:
- Reset values (synchronous, active-high): resp_valid=0, resp_rdata=0, all latency-pipe valids=0, init counter=0.
  - INIT_ON_RESET=1: state=INIT, init_done=0, req_ready=0.
  - INIT_ON_RESET=0: state=READY, init_done=1, req_ready=1.
- FSM: INIT -> READY only. No other transitions except reset.
- INIT state:
  - Each cycle writes INIT_VALUE to word[cnt], then cnt++.
  - On the cycle that writes DEPTH-1, the next state is READY; init_done and req_ready rise the following cycle.
  - The sweep takes exactly DEPTH cycles after reset deasserts.
  - Requests during INIT are ignored, not queued.
- Reset mid-INIT restarts the sweep from address 0. Reset mid-READY drops in-flight reads (no resp_valid) and starts a fresh sweep; array contents are not otherwise cleared.
- READY state: req_ready=1 constantly. A request fires when req_valid && req_ready. One request per cycle (single port).
- Write fire: for each i with req_wmask[i]=1, word[addr] segment i is updated at the clock edge; other segments are unchanged.
  - Mask all-zero is a legal no-op.
  - No response for writes.
- Read fire: word[addr] is sampled at the fire edge. resp_valid=1 and resp_rdata=data exactly READY_LATENCY cycles after the fire cycle; back-to-back reads give back-to-back responses.
  - READ_LATENCY=1 matches the legacy macro timing.
  - Pipeline stages beyond 1 register data and valid together.
- Write then read of the same address in the next cycle returns the new data. A write in cycle N does not affect a read fired in an earlier cycle.
- Cycles with resp_valid=0:
  - HOLD_READ=1: resp_rdata keeps the last response value (0 after reset).
  - HOLD_READ=0: resp_rdata=0. Deterministic, no random fill.
- Out-of-range address (addr >= DEPTH) when DEPTH is not a power of two:
  - Write is dropped.
  - Read responds with 0 at normal latency.
  - An assertion flags it in simulation.
- Init counter width is ADDR_WIDTH. The sweep ends at DEPTH-1 regardless of power-of-two.

Decomposition:
- Shared package sram_pkg: FSM state enum {S_INIT, S_READY}; function for segment width; elaboration checks for legal READ_LATENCY and mask divisibility.
- One sub-module: sram_rd_pipe (READ_LATENCY-deep valid/data shift register with HOLD_READ output mux).
- The array, mask merge and init FSM stay in the top module.

Test Plan:
- Reset 1 cycle, DEPTH=128, INIT_VALUE=0xA5A5A5A5 -> init_done rises exactly 128 cycles after reset falls; reads of addr 0, 77 and 127 return 0xA5A5A5A5.
- Write addr 5 = 0x11223344 (mask 0xF), then write 0xFFFFFFFF with mask 0b0101, then read addr 5 -> 0x11FF33FF.
- READ_LATENCY=3: reads at cycles N, N+1, N+2 to addrs 1, 2, 3 -> resp_valid on N+3, N+4, N+5 with matching data; no gaps.
- HOLD_READ=1: after a read returns 0xDEADBEEF, idle 10 cycles -> rdata stays 0xDEADBEEF with resp_valid=0. Same test with HOLD_READ=0 -> rdata=0 when idle.
- Assert reset at cycle 40 of the sweep -> ready stays 0; full 128-cycle sweep restarts from address 0; a read issued one cycle before a mid-READY reset produces no resp_valid.
- DEPTH=100: write and read at addr 110 -> write dropped, read returns 0, assertion fires; addr 99 works normally.
